// File: rtl/event_arbiter_if.sv
// Bus bundle between the event arbiter (master) and its local/shared FIFO environment (slave).
interface event_arbiter_if #(
  parameter int unsigned NUMCHANNELS = 64,
  parameter int unsigned WIDTH       = 64
);
  localparam int unsigned IDW = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;

  logic                                enable;
  logic [NUMCHANNELS-1:0]              local_fifo_empty;
  logic [NUMCHANNELS-1:0][WIDTH-2:0]   input_event;
  logic                                shared_fifo_full;
  logic [NUMCHANNELS-1:0]              read_local_fifo_n;
  logic [WIDTH-2:0]                    channel_event_out;
  logic                                load_event;
  logic [IDW-1:0]                      grant_id;
  logic                                busy;

  modport master (
    input  enable, local_fifo_empty, input_event, shared_fifo_full,
    output read_local_fifo_n, channel_event_out, load_event, grant_id, busy
  );

  modport slave (
    output enable, local_fifo_empty, input_event, shared_fifo_full,
    input  read_local_fifo_n, channel_event_out, load_event, grant_id, busy
  );
endinterface

// File: rtl/event_arbiter.sv
// Moves one event at a time from per-channel local FIFOs into a shared FIFO.
// Define EVENT_ARBITER_ROUND_ROBIN_EN for round-robin selection; default build is fixed priority.
module event_arbiter #(
  parameter int unsigned NUMCHANNELS  = 64,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  event_arbiter_if.master bus
);
  localparam int unsigned IDW  = (NUMCHANNELS > 1) ? $clog2(NUMCHANNELS) : 1;
  localparam int unsigned EW   = WIDTH - 1;
  localparam int unsigned CNTW = 3;

  typedef enum logic [2:0] {IDLE, READ, WAIT, LOAD, STALL} state_e;

  state_e                 state_q, state_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [NUMCHANNELS-1:0] read_n_q, read_n_d;
  logic [EW-1:0]          event_q, event_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;

  logic [IDW-1:0]         base;
  logic [IDW-1:0]         sel_id;
  logic                   sel_found;
  logic                   can_grant;
  int unsigned            idx;
  logic [IDW-1:0]         idx_v;

`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    if (32'(id) == NUMCHANNELS - 1) return '0;
    return id + IDW'(1);
  endfunction
`endif

  // Search base; in LOAD the pointer update is not yet visible, so use the post-LOAD value directly
  always_comb begin
`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
    base = (state_q == LOAD) ? wrap_inc(grant_q) : ptr_q;
`else
    base = ptr_q;
`endif
  end

  // First non-empty channel at or after base, wrapping upward
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    idx_v     = '0;
    for (int unsigned i = 0; i < NUMCHANNELS; i++) begin
      idx = 32'(base) + i;
      if (idx >= NUMCHANNELS) idx = idx - NUMCHANNELS;
      idx_v = IDW'(idx);
      if (!sel_found && !bus.local_fifo_empty[idx_v]) begin
        sel_found = 1'b1;
        sel_id    = idx_v;
      end
    end
  end

  assign can_grant = bus.enable && !bus.shared_fifo_full && sel_found;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    event_d = event_q;
    unique case (state_q)
      IDLE: begin
        if (can_grant) begin
          state_d = READ;
          grant_d = sel_id;
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNTW'(READ_LATENCY - 1)) begin
          event_d = bus.input_event[grant_q];
          state_d = bus.shared_fifo_full ? STALL : LOAD;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      STALL: begin
        if (!bus.shared_fifo_full) state_d = LOAD;
      end
      LOAD: begin
`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
        ptr_d = wrap_inc(grant_q);
`else
        ptr_d = '0;
`endif
        if (can_grant) begin
          state_d = READ;
          grant_d = sel_id;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    read_n_d = '1;
    if (state_d == READ) read_n_d[grant_d] = 1'b0;
    load_d = (state_d == LOAD);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      read_n_q <= '1;
      event_q  <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      read_n_q <= read_n_d;
      event_q  <= event_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.read_local_fifo_n = read_n_q;
  assign bus.channel_event_out = event_q;
  assign bus.load_event        = load_q;
  assign bus.grant_id          = grant_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_event_arbiter.sv
// Directed self-checking bench for event_arbiter; expectations follow the build's selection mode.
module tb_event_arbiter;
  localparam int unsigned N  = 64;
  localparam int unsigned W  = 64;
  localparam int unsigned RL = 2;
  localparam logic [N-1:0] ALL1 = '1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  event_arbiter_if #(.NUMCHANNELS(N), .WIDTH(W)) bus ();

  event_arbiter #(.NUMCHANNELS(N), .WIDTH(W), .READ_LATENCY(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests     = 0;
  int failures  = 0;
  int model_ptr = 0;

  function automatic logic [W-2:0] ev_val(input int i, input logic [7:0] salt);
    return {salt, 24'(i * 32'h010203), 31'(i * 7 + 3)};
  endfunction

  function automatic logic [N-1:0] mask2(input int a, input int b);
    logic [N-1:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    return m;
  endfunction

  function automatic int model_sel(input logic [N-1:0] req);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (model_ptr + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  function automatic void model_done(input int g);
`ifdef EVENT_ARBITER_ROUND_ROBIN_EN
    model_ptr = (g + 1) % N;
`else
    if (g < 0) model_ptr = 0;
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (bus.read_local_fifo_n !== ALL1) ok = 1'b1;
    end
    if (!ok) begin
      tests++; failures++;
      $display("FAIL strobe_timeout: no read strobe within 20 cycles");
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(); step();
    tests++; if (bus.read_local_fifo_n !== ALL1) begin failures++; $display("FAIL reset_read_n: got %h want %h", bus.read_local_fifo_n, ALL1); end
    tests++; if (bus.channel_event_out !== '0) begin failures++; $display("FAIL reset_event: got %h want 0", bus.channel_event_out); end
    tests++; if (bus.load_event !== 1'b0) begin failures++; $display("FAIL reset_load: got %b want 0", bus.load_event); end
    tests++; if (bus.grant_id !== 6'd0) begin failures++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
    tests++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic do_txn(input logic [N-1:0] req, input string name);
    bit ok;
    int g;
    logic [N-1:0] exp_n;
    g = model_sel(req);
    bus.local_fifo_empty = ~req;
    wait_strobe(ok);
    bus.local_fifo_empty = ALL1;
    if (ok) begin
      exp_n = ALL1; exp_n[g] = 1'b0;
      tests++; if (bus.read_local_fifo_n !== exp_n) begin failures++; $display("FAIL %s_strobe: got %h want %h", name, bus.read_local_fifo_n, exp_n); end
      tests++; if (bus.grant_id !== 6'(g)) begin failures++; $display("FAIL %s_grant: got %0d want %0d", name, bus.grant_id, g); end
      tests++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s_busy: got %b want 1", name, bus.busy); end
      step();
      tests++; if (bus.read_local_fifo_n !== ALL1 || bus.load_event !== 1'b0) begin failures++; $display("FAIL %s_t1: read_n %h load %b want all ones / 0", name, bus.read_local_fifo_n, bus.load_event); end
      step();
      tests++; if (bus.load_event !== 1'b0) begin failures++; $display("FAIL %s_t2_load: got %b want 0", name, bus.load_event); end
      step();
      tests++; if (bus.load_event !== 1'b1) begin failures++; $display("FAIL %s_t3_load: got %b want 1", name, bus.load_event); end
      tests++; if (bus.channel_event_out !== ev_val(g, 8'h11)) begin failures++; $display("FAIL %s_data: got %h want %h", name, bus.channel_event_out, ev_val(g, 8'h11)); end
      step();
      tests++; if (bus.load_event !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL %s_idle: load %b busy %b want 0 0", name, bus.load_event, bus.busy); end
      model_done(g);
    end
  endtask

  task automatic test_single;
    do_txn(mask2(5, -1), "single_ch5");
  endtask

  task automatic test_back_to_back(input int a, input int b, input string name);
    bit ok;
    int g;
    logic [N-1:0] req, exp_n;
    req = mask2(a, b);
    bus.local_fifo_empty = ~req;
    wait_strobe(ok);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        g = model_sel(req);
        exp_n = ALL1; exp_n[g] = 1'b0;
        tests++; if (bus.read_local_fifo_n !== exp_n || bus.grant_id !== 6'(g)) begin failures++; $display("FAIL %s_grant%0d: read_n %h grant %0d want %h / %0d", name, k, bus.read_local_fifo_n, bus.grant_id, exp_n, g); end
        if (k == 3) bus.local_fifo_empty = ALL1;
        step(); step(); step();
        tests++; if (bus.load_event !== 1'b1 || bus.channel_event_out !== ev_val(g, 8'h11)) begin failures++; $display("FAIL %s_load%0d: load %b data %h want 1 / %h", name, k, bus.load_event, bus.channel_event_out, ev_val(g, 8'h11)); end
        model_done(g);
        step();
      end
      tests++; if (bus.busy !== 1'b0 || bus.read_local_fifo_n !== ALL1) begin failures++; $display("FAIL %s_end: busy %b read_n %h want 0 / all ones", name, bus.busy, bus.read_local_fifo_n); end
    end
    bus.local_fifo_empty = ALL1;
  endtask

  task automatic test_wrap;
    do_txn(mask2(62, -1), "wrap_ch62");
    do_txn(mask2(0, 61), "wrap_next");
  endtask

  task automatic test_stall;
    bit ok;
    bus.local_fifo_empty = ~mask2(7, -1);
    wait_strobe(ok);
    bus.local_fifo_empty = ALL1;
    if (ok) begin
      step();
      bus.shared_fifo_full = 1'b1;
      step(); step();
      bus.input_event[7] = ev_val(7, 8'h22);
      for (int i = 0; i < 10; i++) begin
        tests++; if (bus.load_event !== 1'b0 || bus.busy !== 1'b1 || bus.channel_event_out !== ev_val(7, 8'h11)) begin failures++; $display("FAIL stall_hold%0d: load %b busy %b data %h want 0 1 %h", i, bus.load_event, bus.busy, bus.channel_event_out, ev_val(7, 8'h11)); end
        if (i < 9) step();
      end
      bus.shared_fifo_full = 1'b0;
      step();
      tests++; if (bus.load_event !== 1'b1 || bus.channel_event_out !== ev_val(7, 8'h11)) begin failures++; $display("FAIL stall_release: load %b data %h want 1 %h", bus.load_event, bus.channel_event_out, ev_val(7, 8'h11)); end
      step();
      tests++; if (bus.load_event !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stall_single_pulse: load %b busy %b want 0 0", bus.load_event, bus.busy); end
      model_done(7);
    end
    bus.shared_fifo_full = 1'b0;
    bus.input_event[7] = ev_val(7, 8'h11);
  endtask

  task automatic test_enable_drop;
    bit ok;
    bus.local_fifo_empty = ~mask2(9, -1);
    wait_strobe(ok);
    bus.enable = 1'b0;
    if (ok) begin
      step(); step(); step();
      tests++; if (bus.load_event !== 1'b1 || bus.channel_event_out !== ev_val(9, 8'h11)) begin failures++; $display("FAIL enable_drop_load: load %b data %h want 1 %h", bus.load_event, bus.channel_event_out, ev_val(9, 8'h11)); end
      model_done(9);
      for (int i = 0; i < 4; i++) begin
        step();
        tests++; if (bus.busy !== 1'b0 || bus.read_local_fifo_n !== ALL1) begin failures++; $display("FAIL enable_drop_idle%0d: busy %b read_n %h want 0 / all ones", i, bus.busy, bus.read_local_fifo_n); end
      end
    end
    bus.local_fifo_empty = ALL1;
    bus.enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.local_fifo_empty = ~mask2(4, -1);
    wait_strobe(ok);
    bus.local_fifo_empty = ALL1;
    if (ok) begin
      step();
      reset_n = 1'b0;
      #1;
      tests++; if (bus.read_local_fifo_n !== ALL1 || bus.load_event !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_mid_ctrl: read_n %h load %b busy %b want all ones 0 0", bus.read_local_fifo_n, bus.load_event, bus.busy); end
      tests++; if (bus.channel_event_out !== '0 || bus.grant_id !== 6'd0) begin failures++; $display("FAIL reset_mid_data: data %h grant %0d want 0 0", bus.channel_event_out, bus.grant_id); end
      step();
      reset_n = 1'b1;
      model_ptr = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        tests++; if (bus.load_event !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet%0d: load %b busy %b want 0 0", i, bus.load_event, bus.busy); end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b1;
    bus.local_fifo_empty = ALL1;
    bus.shared_fifo_full = 1'b0;
    for (int i = 0; i < N; i++) bus.input_event[i] = ev_val(i, 8'h11);

    test_reset();
    test_single();
    test_back_to_back(3, 60, "b2b_3_60");
    test_back_to_back(2, 9, "b2b_2_9");
    test_wrap();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    do_txn(mask2(1, 10), "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter NUMCHANNELS, default 64: number of channel local FIFOs arbitrated.
REQ-002 Parameter WIDTH, default 64: event width including parity; the datapath carries WIDTH-1 bits.
REQ-003 Parameter READ_LATENCY, default 2: cycles from read strobe to valid local FIFO data; legal range 1-7.
REQ-004 clk  input  1  master clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  high permits new grants.
REQ-007 local_fifo_empty  input  NUMCHANNELS  per-channel empty flag; low means an event is waiting.
REQ-008 input_event  input  [WIDTH-2:0] x NUMCHANNELS  per-channel local FIFO data.
REQ-009 shared_fifo_full  input  1  shared FIFO backpressure.
REQ-010 read_local_fifo_n  output  NUMCHANNELS  active-low per-channel read strobe, registered.
REQ-011 channel_event_out  output  WIDTH-1  routed event (pre-parity), registered.
REQ-012 load_event  output  1  one-cycle pulse; channel_event_out is valid in that cycle.
REQ-013 grant_id  output  $clog2(NUMCHANNELS)  index of the channel currently or last granted.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, READ, WAIT, LOAD and STALL.
REQ-016 IDLE->READ when enable=1, shared_fifo_full=0 and any local_fifo_empty bit=0; the selected channel is latched into grant_id on that edge.
REQ-017 In READ, only bit read_local_fifo_n[grant_id] SHALL be low, for exactly one cycle; all other bits stay high.
REQ-018 READ->WAIT; WAIT lasts READ_LATENCY cycles, counted by a 3-bit counter cleared on entry.
REQ-019 At the end of WAIT, input_event[grant_id] SHALL be captured into channel_event_out.
REQ-020 WAIT->LOAD if shared_fifo_full=0; otherwise WAIT->STALL.
REQ-021 In STALL, channel_event_out SHALL hold and load_event SHALL stay low; STALL->LOAD on the first cycle shared_fifo_full=0.
REQ-022 In LOAD, load_event=1 for one cycle; the round-robin pointer SHALL be set to (grant_id+1) mod NUMCHANNELS, wrapping NUMCHANNELS-1 to 0.
REQ-023 LOAD->READ when the IDLE conditions hold (new grant latched); otherwise LOAD->IDLE.
REQ-024 Latency: read strobe in cycle T gives load_event in cycle T+READ_LATENCY+1 when not stalled.
REQ-025 Throughput: back-to-back events SHALL be spaced READ_LATENCY+2 cycles apart.
REQ-026 Channel selection SHALL pick the first non-empty channel at or after the pointer, searching upward with wrap.
REQ-027 Deasserting enable mid-transaction SHALL NOT abort the transaction; the current event completes through LOAD, then the FSM goes to IDLE.
REQ-028 local_fifo_empty changes after a grant SHALL NOT affect the granted transaction.
REQ-029 At most one read strobe SHALL be asserted per transaction; at most one load_event SHALL be issued per read strobe.

Reset
REQ-030 Reset SHALL take effect immediately, including mid-transaction, with no event emitted.
REQ-031 Reset values: FSM=IDLE, read_local_fifo_n=all ones, channel_event_out=0, load_event=0, grant_id=0, busy=0, pointer=0, wait counter=0.

Configuration
REQ-032 With macro EVENT_ARBITER_ROUND_ROBIN_EN defined, selection SHALL be round-robin as in REQ-026 and REQ-022.
REQ-033 Without EVENT_ARBITER_ROUND_ROBIN_EN, selection SHALL be fixed priority (lowest non-empty index wins), the pointer SHALL be constant 0, and all other behaviour is unchanged.

Verification
REQ-034 Empty flag of ch5 low, all others high, enable=1, full=0 -> read_n[5] low in cycle T; load_event in T+3 with channel_event_out=input_event[5]; grant_id=5.
REQ-035 (round-robin build) ch3 and ch60 held non-empty continuously -> grants alternate 3,60,3,60 at 4-cycle spacing.
REQ-036 (round-robin build) pointer=63 after a ch62 grant, ch63 empty, ch0 non-empty -> next grant is ch0 (wrap).
REQ-037 shared_fifo_full=1 at the end of WAIT, held for 10 cycles -> STALL, load_event low for 10 cycles, then one pulse carrying the unchanged data.
REQ-038 reset_n asserted during WAIT -> all outputs at reset values immediately; no load_event after release until a new grant.
REQ-039 (fixed-priority build) ch2 and ch9 continuously non-empty -> only ch2 is granted.
